stream_packet_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares one AXI-Stream output channel among N requesting stream sources. A grant is held for a whole packet, from first beat to the beat with t_last, so packets are never interleaved on the shared output. The output side is a registered forward slice, and the index of the granted source is reported alongside each beat. The block sits upstream of shared stream resources such as stream_widener or DMA egress.

---
 rtl/stream_packet_arbiter.sv | 158 +++++++++++++++
 tb/tb_stream_packet_arbiter.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_packet_arbiter.sv
// Packet-level round-robin arbiter: N AXI-Stream sources share one output channel.
// A grant is held from first beat to t_last; the output side is a registered forward slice.
module stream_packet_arbiter #(
    parameter  int N          = 4,
    parameter  int DATA_WIDTH = 64,
    parameter  int ID_WIDTH   = 1,
    parameter  int DEST_WIDTH = 1,
    parameter  int USER_WIDTH = 1,
    localparam int SEL_WIDTH  = $clog2(N),
    localparam int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N-1:0]              en,
    input  logic [N-1:0]              s_t_valid,
    output logic [N-1:0]              s_t_ready,
    input  logic [N*DATA_WIDTH-1:0]   s_t_data,
    input  logic [N*KEEP_WIDTH-1:0]   s_t_strb,
    input  logic [N*KEEP_WIDTH-1:0]   s_t_keep,
    input  logic [N-1:0]              s_t_last,
    input  logic [N*ID_WIDTH-1:0]     s_t_id,
    input  logic [N*DEST_WIDTH-1:0]   s_t_dest,
    input  logic [N*USER_WIDTH-1:0]   s_t_user,
    output logic                      m_t_valid,
    input  logic                      m_t_ready,
    output logic [DATA_WIDTH-1:0]     m_t_data,
    output logic [KEEP_WIDTH-1:0]     m_t_strb,
    output logic [KEEP_WIDTH-1:0]     m_t_keep,
    output logic                      m_t_last,
    output logic [ID_WIDTH-1:0]       m_t_id,
    output logic [DEST_WIDTH-1:0]     m_t_dest,
    output logic [USER_WIDTH-1:0]     m_t_user,
    output logic [SEL_WIDTH-1:0]      m_src,
    output logic                      busy,
    output logic [SEL_WIDTH-1:0]      grant
);

    if (N < 2) begin : g_bad_n
        $fatal(1, "stream_packet_arbiter: N must be >= 2");
    end
    if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
        $fatal(1, "stream_packet_arbiter: DATA_WIDTH must be a multiple of 8");
    end

    typedef enum logic {IDLE, LOCKED} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [KEEP_WIDTH-1:0] strb;
        logic [KEEP_WIDTH-1:0] keep;
        logic                  last;
        logic [ID_WIDTH-1:0]   id;
        logic [DEST_WIDTH-1:0] dest;
        logic [USER_WIDTH-1:0] user;
    } beat_t;

    state_t               state, state_nxt;
    logic [SEL_WIDTH-1:0] ptr, grant_q, src_q;
    logic [SEL_WIDTH-1:0] idx_hi, idx_lo, pick;
    logic                 found_hi, found_lo, pick_found;
    logic [N-1:0]         cand;
    logic                 sel_valid, can_load, accept, out_valid;
    beat_t                sel_beat, out_beat;

    assign cand     = s_t_valid & en;
    assign can_load = !out_valid || m_t_ready;
    assign accept   = (state == LOCKED) && can_load && sel_valid;

    // Cyclic search from ptr+1: lowest candidate above ptr wins, else lowest at or below it.
    // NOTE: every always_comb output is defaulted first so no latch can be inferred.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int i = 0; i < N; i++) begin
            if (cand[i] && !found_hi && (SEL_WIDTH'(i) > ptr)) begin
                found_hi = 1'b1;
                idx_hi   = SEL_WIDTH'(i);
            end
            if (cand[i] && !found_lo && (SEL_WIDTH'(i) <= ptr)) begin
                found_lo = 1'b1;
                idx_lo   = SEL_WIDTH'(i);
            end
        end
        pick_found = found_hi || found_lo;
        pick       = found_hi ? idx_hi : idx_lo;
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_beat  = '0;
        s_t_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q == SEL_WIDTH'(i)) begin
                sel_valid     = s_t_valid[i];
                sel_beat.data = s_t_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_beat.strb = s_t_strb[i*KEEP_WIDTH +: KEEP_WIDTH];
                sel_beat.keep = s_t_keep[i*KEEP_WIDTH +: KEEP_WIDTH];
                sel_beat.last = s_t_last[i];
                sel_beat.id   = s_t_id[i*ID_WIDTH +: ID_WIDTH];
                sel_beat.dest = s_t_dest[i*DEST_WIDTH +: DEST_WIDTH];
                sel_beat.user = s_t_user[i*USER_WIDTH +: USER_WIDTH];
                s_t_ready[i]  = (state == LOCKED) && can_load;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_found) state_nxt = LOCKED;
            LOCKED:  if (accept && sel_beat.last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: registers update with non-blocking assignments so every process sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= SEL_WIDTH'(N - 1);
            grant_q   <= '0;
            src_q     <= '0;
            out_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_found) begin
                grant_q <= pick;
                ptr     <= pick;
            end
            if (accept) begin
                out_valid <= 1'b1;
                src_q     <= grant_q;
            end else if (m_t_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // NOTE: payload register has no reset; m_t_valid alone qualifies its contents.
    always_ff @(posedge clk) begin
        if (accept) out_beat <= sel_beat;
    end

    assign m_t_valid = out_valid;
    assign m_t_data  = out_beat.data;
    assign m_t_strb  = out_beat.strb;
    assign m_t_keep  = out_beat.keep;
    assign m_t_last  = out_beat.last;
    assign m_t_id    = out_beat.id;
    assign m_t_dest  = out_beat.dest;
    assign m_t_user  = out_beat.user;
    assign m_src     = src_q;
    assign busy      = (state == LOCKED);
    assign grant     = grant_q;

endmodule

// File: tb/tb_stream_packet_arbiter.sv
// Self-checking bench for stream_packet_arbiter: packet-level reference model and
// scoreboard, directed scenarios followed by a randomized soak with backpressure.
module tb_stream_packet_arbiter;

    localparam int N   = 4;
    localparam int DW  = 16;
    localparam int KW  = DW / 8;
    localparam int IW  = 2;
    localparam int DSW = 2;
    localparam int UW  = 2;
    localparam int SW  = 2;

    typedef struct packed {
        logic [DW-1:0]  data;
        logic [KW-1:0]  strb;
        logic [KW-1:0]  keep;
        logic           last;
        logic [IW-1:0]  id;
        logic [DSW-1:0] dest;
        logic [UW-1:0]  user;
        logic [SW-1:0]  src;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    en = '0;
    logic [N-1:0]    s_t_valid = '0;
    logic [N-1:0]    s_t_ready;
    logic [N*DW-1:0] s_t_data = '0;
    logic [N*KW-1:0] s_t_strb = '0;
    logic [N*KW-1:0] s_t_keep = '0;
    logic [N-1:0]    s_t_last = '0;
    logic [N*IW-1:0] s_t_id = '0;
    logic [N*DSW-1:0] s_t_dest = '0;
    logic [N*UW-1:0] s_t_user = '0;
    logic            m_t_valid;
    logic            m_t_ready = 1'b0;
    logic [DW-1:0]   m_t_data;
    logic [KW-1:0]   m_t_strb;
    logic [KW-1:0]   m_t_keep;
    logic            m_t_last;
    logic [IW-1:0]   m_t_id;
    logic [DSW-1:0]  m_t_dest;
    logic [UW-1:0]   m_t_user;
    logic [SW-1:0]   m_src;
    logic            busy;
    logic [SW-1:0]   grant;

    stream_packet_arbiter #(
        .N(N), .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(DSW), .USER_WIDTH(UW)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .s_t_valid(s_t_valid), .s_t_ready(s_t_ready), .s_t_data(s_t_data),
        .s_t_strb(s_t_strb), .s_t_keep(s_t_keep), .s_t_last(s_t_last),
        .s_t_id(s_t_id), .s_t_dest(s_t_dest), .s_t_user(s_t_user),
        .m_t_valid(m_t_valid), .m_t_ready(m_t_ready), .m_t_data(m_t_data),
        .m_t_strb(m_t_strb), .m_t_keep(m_t_keep), .m_t_last(m_t_last),
        .m_t_id(m_t_id), .m_t_dest(m_t_dest), .m_t_user(m_t_user),
        .m_src(m_src), .busy(busy), .grant(grant)
    );

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    beat_t exp_q[$];
    beat_t out_log[$];
    int    out_cyc[$];
    beat_t pend[N][$];
    int    taken[N];
    int    ready_mode = 0;
    bit    bubbles = 1'b0;
    int    pat_cnt = 0;

    // reference model state (packet-level view of the arbiter)
    bit           md_locked;
    int           md_ptr;
    int           md_grant;
    bit           md_full;
    logic [N-1:0] md_exp_rdy;
    logic [N-1:0] md_cand;
    bit           md_fire;
    bit           md_found;

    beat_t om_cur;
    beat_t om_held_beat;
    bit    om_held = 1'b0;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic beat_t in_beat(input int i);
        beat_t b;
        b.data = s_t_data[i*DW +: DW];
        b.strb = s_t_strb[i*KW +: KW];
        b.keep = s_t_keep[i*KW +: KW];
        b.last = s_t_last[i];
        b.id   = s_t_id[i*IW +: IW];
        b.dest = s_t_dest[i*DSW +: DSW];
        b.user = s_t_user[i*UW +: UW];
        b.src  = SW'(i);
        return b;
    endfunction

    // Input-side model: predicts s_t_ready, busy, grant, m_t_valid and pushes accepted beats.
    initial begin : in_mon
        forever begin
            @(negedge clk);
            if (rst) begin
                md_locked = 1'b0;
                md_ptr    = N - 1;
                md_grant  = 0;
                md_full   = 1'b0;
                exp_q.delete();
            end else begin
                md_exp_rdy = '0;
                if (md_locked && (!md_full || m_t_ready)) md_exp_rdy[md_grant] = 1'b1;
                check("s_t_ready", s_t_ready, md_exp_rdy);
                check("busy", busy, md_locked);
                check("grant", grant, md_grant);
                check("m_t_valid", m_t_valid, md_full);
                md_fire = md_locked && md_exp_rdy[md_grant] && s_t_valid[md_grant];
                if (md_fire) exp_q.push_back(in_beat(md_grant));
                if (!md_locked) begin
                    md_cand  = s_t_valid & en;
                    md_found = 1'b0;
                    for (int k = 1; k <= N; k++) begin
                        int j;
                        j = (md_ptr + k) % N;
                        if (!md_found && md_cand[j]) begin
                            md_found  = 1'b1;
                            md_locked = 1'b1;
                            md_grant  = j;
                            md_ptr    = j;
                        end
                    end
                end else if (md_fire && s_t_last[md_grant]) begin
                    md_locked = 1'b0;
                end
                md_full = md_fire ? 1'b1 : (m_t_ready ? 1'b0 : md_full);
            end
        end
    end

    // Output-side monitor: pops the scoreboard on each output handshake and checks stability.
    initial begin : out_mon
        forever begin
            @(negedge clk);
            om_cur = {m_t_data, m_t_strb, m_t_keep, m_t_last, m_t_id, m_t_dest, m_t_user, m_src};
            if (rst) begin
                om_held = 1'b0;
            end else begin
                if (om_held && m_t_valid) check("hold_stable", om_cur, om_held_beat);
                if (m_t_valid && m_t_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL beat: got unexpected beat 0x%0h, expected none", om_cur);
                    end else begin
                        check("beat", om_cur, exp_q.pop_front());
                    end
                    out_log.push_back(om_cur);
                    out_cyc.push_back(cyc);
                    om_held = 1'b0;
                end else begin
                    om_held      = m_t_valid;
                    om_held_beat = om_cur;
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic drive_src(input int i, input beat_t b);
        s_t_data[i*DW +: DW]   = b.data;
        s_t_strb[i*KW +: KW]   = b.strb;
        s_t_keep[i*KW +: KW]   = b.keep;
        s_t_last[i]            = b.last;
        s_t_id[i*IW +: IW]     = b.id;
        s_t_dest[i*DSW +: DSW] = b.dest;
        s_t_user[i*UW +: UW]   = b.user;
    endtask

    task automatic flush_sources();
        for (int i = 0; i < N; i++) begin
            pend[i].delete();
            taken[i] = 0;
        end
        s_t_valid = '0;
        s_t_last  = '0;
    endtask

    task automatic add_packet(input int src, input int len, input int base, input bit rnd);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = rnd ? DW'($urandom) : DW'(base + k);
            b.strb = rnd ? KW'($urandom) : '1;
            b.keep = rnd ? KW'($urandom) : '1;
            b.last = (k == len - 1);
            b.id   = rnd ? IW'($urandom) : IW'(src);
            b.dest = rnd ? DSW'($urandom) : DSW'(k);
            b.user = rnd ? UW'($urandom) : UW'(len);
            b.src  = SW'(src);
            pend[src].push_back(b);
        end
    endtask

    // One clock: observe handshakes, then present next beats and output ready after the edge.
    task automatic cycle();
        logic [N-1:0] hs;
        @(negedge clk);
        hs = s_t_valid & s_t_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                void'(pend[i].pop_front());
                taken[i]++;
            end
            if (pend[i].size() == 0) begin
                s_t_valid[i] = 1'b0;
            end else begin
                if (!s_t_valid[i] || hs[i]) s_t_valid[i] = bubbles ? ($urandom_range(3) != 0) : 1'b1;
                drive_src(i, pend[i][0]);
            end
        end
        pat_cnt++;
        case (ready_mode)
            0:       m_t_ready = 1'b1;
            1:       m_t_ready = ($urandom_range(3) != 0);
            default: m_t_ready = (pat_cnt % 3 == 0);
        endcase
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush_sources();
        #1;
        check("rst_m_t_valid", m_t_valid, 0);
        check("rst_s_t_ready", s_t_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_m_src", m_src, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        out_log.delete();
        out_cyc.delete();
    endtask

    task automatic wait_log(input int n, input int bound, input string name);
        int t;
        t = 0;
        while (out_log.size() < n && t < bound) begin
            cycle();
            t++;
        end
        checks++;
        if (out_log.size() < n) begin
            errors++;
            $display("FAIL %s_timeout: got %0d output beats, expected %0d", name, out_log.size(), n);
        end
    endtask

    initial begin : stim
        int exp_src[$];
        #2;
        ready_mode = 0;
        bubbles    = 1'b0;

        // single requester: 3 beats from source 2 at full rate
        do_reset();
        en = 4'b1111;
        add_packet(2, 3, 'hA0, 1'b0);
        wait_log(3, 50, "single");
        for (int i = 0; i < 3 && i < out_log.size(); i++) begin
            check("single_src", out_log[i].src, 2);
            check("single_data", out_log[i].data, 'hA0 + i);
            check("single_last", out_log[i].last, (i == 2));
            if (i > 0) check("single_rate", out_cyc[i] - out_cyc[i-1], 1);
        end
        check("single_busy_after", busy, 0);

        // round robin: all four sources stream 1-beat packets
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) add_packet(i, 1, 'h10 * i + r, 1'b0);
        wait_log(8, 100, "rr");
        exp_src = '{0, 1, 2, 3, 0, 1, 2, 3};
        for (int i = 0; i < 8 && i < out_log.size(); i++) begin
            check("rr_src", out_log[i].src, exp_src[i]);
            if (i > 0) check("rr_gap", out_cyc[i] - out_cyc[i-1], 2);
        end

        // packet lock: source 1 keeps its grant even after en[1] drops
        do_reset();
        add_packet(1, 4, 'h10, 1'b0);
        cycle();
        cycle();
        add_packet(0, 1, 'h20, 1'b0);
        for (int t = 0; t < 20 && taken[1] < 2; t++) cycle();
        en[1] = 1'b0;
        wait_log(5, 100, "lock");
        exp_src = '{1, 1, 1, 1, 0};
        for (int i = 0; i < 5 && i < out_log.size(); i++)
            check("lock_src", out_log[i].src, exp_src[i]);
        en = 4'b1111;

        // backpressure: ready pattern 1,0,0 during a 5-beat packet from source 3
        out_log.delete();
        out_cyc.delete();
        ready_mode = 2;
        add_packet(3, 5, 'h30, 1'b0);
        wait_log(5, 200, "bp");
        for (int i = 0; i < 5 && i < out_log.size(); i++) begin
            check("bp_src", out_log[i].src, 3);
            check("bp_data", out_log[i].data, 'h30 + i);
        end
        ready_mode = 0;

        // enable mask 0101: only sources 0 and 2 alternate
        do_reset();
        en = 4'b0101;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) add_packet(i, 1, 'h40 + i, 1'b0);
        wait_log(4, 100, "mask");
        exp_src = '{0, 2, 0, 2};
        for (int i = 0; i < 4 && i < out_log.size(); i++)
            check("mask_src", out_log[i].src, exp_src[i]);
        flush_sources();
        en = 4'b1111;

        // mid-packet reset during beat 2 of source 1
        do_reset();
        add_packet(1, 4, 'h50, 1'b0);
        for (int t = 0; t < 20 && taken[1] < 2; t++) cycle();
        rst = 1'b1;
        #1;
        check("midrst_m_t_valid", m_t_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_s_t_ready", s_t_ready, 0);
        flush_sources();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_log.delete();
        out_cyc.delete();
        add_packet(1, 1, 'h60, 1'b0);
        add_packet(0, 1, 'h70, 1'b0);
        wait_log(2, 50, "midrst");
        exp_src = '{0, 1};
        for (int i = 0; i < 2 && i < out_log.size(); i++)
            check("midrst_src", out_log[i].src, exp_src[i]);

        // randomized soak: random packets, enables, bubbles and backpressure
        do_reset();
        en         = 4'b1111;
        ready_mode = 1;
        bubbles    = 1'b1;
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(2) == 0) begin
                int s;
                s = $urandom_range(N - 1);
                if (pend[s].size() < 8) add_packet(s, $urandom_range(5, 1), 0, 1'b1);
            end
            if (t % 64 == 63) en = N'($urandom);
            cycle();
        end
        en         = 4'b1111;
        ready_mode = 0;
        begin
            int  t;
            bit  done;
            t    = 0;
            done = 1'b0;
            while (!done && t < 3000) begin
                cycle();
                t++;
                done = (exp_q.size() == 0) && !m_t_valid;
                for (int i = 0; i < N; i++) if (pend[i].size() != 0) done = 1'b0;
            end
            checks++;
            if (!done) begin
                errors++;
                $display("FAIL drain_timeout: got %0d beats still pending, expected 0", exp_q.size());
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
